// File: rtl/pmc_readout_pkg.sv
// Shared register map, CTRL/STATUS bit positions and packed register views
// for the PMC readout FIFO block.
package pmc_readout_pkg;

  localparam int DATA_W = 64;
  localparam int BUS_W  = 32;
  localparam int ADDR_W = 4;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_DATA_LO = 2'd2;
  localparam logic [1:0] REG_DATA_HI = 2'd3;

  localparam int CTRL_EN_BIT     = 0;
  localparam int CTRL_CLR_BIT    = 1;
  localparam int CTRL_IRQ_EN_BIT = 2;

  localparam int STAT_EMPTY_BIT = 8;
  localparam int STAT_FULL_BIT  = 9;
  localparam int STAT_OVF_BIT   = 10;
  localparam int STAT_UDF_BIT   = 11;

  typedef struct packed {
    logic [28:0] rsvd;
    logic        irq_en;
    logic        clr;
    logic        en;
  } ctrl_t;

  typedef struct packed {
    logic [19:0] rsvd_hi;
    logic        udf;
    logic        ovf;
    logic        full;
    logic        empty;
    logic        rsvd_lo;
    logic [6:0]  count;
  } status_t;

endpackage

// File: rtl/pmc_readout_fifo_if.sv
// Data-bus slave port of the readout FIFO: req/we/addr/wdata in, gnt/rvalid/rdata out.
// gnt is combinational; rvalid/rdata follow one cycle after the granted request.
interface pmc_readout_fifo_if;
  import pmc_readout_pkg::*;

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [BUS_W-1:0]  wdata;
  logic              gnt;
  logic              rvalid;
  logic [BUS_W-1:0]  rdata;

  modport master (
    output req, we, addr, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/pmc_fifo64.sv
// 64-bit circular FIFO, head visible combinationally; push/pop take effect on the edge.
// No backpressure: a push when full (without pop) or a pop when empty is ignored.
module pmc_fifo64 #(
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [63:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));

  // A pop frees the head slot in the same edge, so a full FIFO can still accept.
  assign do_pop  = pop & ~empty & ~clr;
  assign do_push = push & (~full | do_pop) & ~clr;

  always_ff @(posedge clk) begin
    if (do_push && !rst) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  assign rdata = mem[rd_ptr];
  assign count = cnt;

endmodule

// File: rtl/pmc_readout_fifo.sv
// Captures pixel-matrix words into a FIFO drained over a 32-bit register bus.
// Bus completes one cycle after every request; captures never stall and are dropped (ovf) when full.
module pmc_readout_fifo
  import pmc_readout_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                capture,
  input  logic [DATA_W-1:0]   dout,
  pmc_readout_fifo_if.slave   bus,
  output logic                irq
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic              en;
  logic              irq_en;
  logic              ovf;
  logic              udf;
  logic              rvalid_q;
  logic [BUS_W-1:0]  rdata_q;
  logic              irq_q;

  logic [DATA_W-1:0] head;
  logic [CW-1:0]     count;
  logic              empty;
  logic              full;

  logic              rd_req;
  logic              wr_req;
  logic [1:0]        reg_sel;
  logic              ctrl_wr;
  logic              stat_wr;
  logic              data_rd;
  logic              clr;
  logic              pop;
  logic              push;
  logic              ovf_set;
  logic              udf_set;
  logic              ovf_w1c;
  logic              udf_w1c;

  ctrl_t             ctrl_view;
  status_t           status_view;
  logic [BUS_W-1:0]  rd_word;
  logic              unused_bits;

  assign reg_sel = bus.addr[3:2];
  assign rd_req  = bus.req & ~bus.we;
  assign wr_req  = bus.req & bus.we;
  assign ctrl_wr = wr_req & (reg_sel == REG_CTRL);
  assign stat_wr = wr_req & (reg_sel == REG_STATUS);
  assign data_rd = rd_req & ((reg_sel == REG_DATA_LO) | (reg_sel == REG_DATA_HI));

  assign clr     = ctrl_wr & bus.wdata[CTRL_CLR_BIT];
  assign pop     = rd_req & (reg_sel == REG_DATA_HI) & ~empty;
  // clr wins over a coincident capture: the sample is discarded, not counted as overflow.
  assign push    = capture & en & (~full | pop) & ~clr;
  assign ovf_set = capture & en & full & ~pop & ~clr;
  assign udf_set = data_rd & empty;
  assign ovf_w1c = stat_wr & bus.wdata[STAT_OVF_BIT];
  assign udf_w1c = stat_wr & bus.wdata[STAT_UDF_BIT];

  assign unused_bits = ^{bus.addr[1:0], bus.wdata[31:12], bus.wdata[9:3]};

  pmc_fifo64 #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .clr   (clr),
    .push  (push),
    .pop   (pop),
    .wdata (dout),
    .rdata (head),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  always_comb begin
    ctrl_view        = '0;
    ctrl_view.en     = en;
    ctrl_view.irq_en = irq_en;

    status_view       = '0;
    status_view.count = 7'(count);
    status_view.empty = empty;
    status_view.full  = full;
    status_view.ovf   = ovf;
    status_view.udf   = udf;

    rd_word = '0;
    case (reg_sel)
      REG_CTRL:    rd_word = ctrl_view;
      REG_STATUS:  rd_word = status_view;
      REG_DATA_LO: rd_word = empty ? '0 : head[31:0];
      default:     rd_word = empty ? '0 : head[63:32];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en       <= 1'b0;
      irq_en   <= 1'b0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
    end else begin
      rvalid_q <= bus.req;
      rdata_q  <= rd_req ? rd_word : '0;
      if (ctrl_wr) begin
        en     <= bus.wdata[CTRL_EN_BIT];
        irq_en <= bus.wdata[CTRL_IRQ_EN_BIT];
      end
      // A set event in the same cycle as the W1C keeps the flag set.
      ovf   <= (ovf & ~ovf_w1c) | ovf_set;
      udf   <= (udf & ~udf_w1c) | udf_set;
      irq_q <= irq_en & ~empty;
    end
  end

  assign bus.gnt    = bus.req;
  assign bus.rvalid = rvalid_q;
  assign bus.rdata  = rdata_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_pmc_readout_fifo.sv
// Self-checking bench: directed vector table, corner-case sequences and a
// randomized run against a queue-based model of the readout FIFO.
module tb_pmc_readout_fifo;
  import pmc_readout_pkg::*;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        capture = 1'b0;
  logic [63:0] dout = '0;
  logic        irq;

  pmc_readout_fifo_if bus ();

  pmc_readout_fifo #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .capture (capture),
    .dout    (dout),
    .bus     (bus),
    .irq     (irq)
  );

  always #5 clk = ~clk;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_rd;

  // Model state
  logic [63:0] mq[$];
  logic        m_en;
  logic        m_irq_en;
  logic        m_ovf;
  logic        m_udf;

  typedef struct {
    logic        cap;
    logic [63:0] d;
    logic        req;
    logic        we;
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a);
    logic [31:0] r;
    logic [63:0] h;
    r = '0;
    h = (mq.size() != 0) ? mq[0] : 64'd0;
    case (a[3:2])
      2'd0: begin
        r[CTRL_EN_BIT]     = m_en;
        r[CTRL_IRQ_EN_BIT] = m_irq_en;
      end
      2'd1: begin
        r[6:0]            = 7'(mq.size());
        r[STAT_EMPTY_BIT] = (mq.size() == 0);
        r[STAT_FULL_BIT]  = (mq.size() == DEPTH);
        r[STAT_OVF_BIT]   = m_ovf;
        r[STAT_UDF_BIT]   = m_udf;
      end
      2'd2:    r = h[31:0];
      default: r = h[63:32];
    endcase
    return r;
  endfunction

  task automatic model_step(input logic cap, input logic [63:0] d, input logic rq,
                            input logic w, input logic [3:0] a, input logic [31:0] wd);
    logic is_clr, ovf_s, udf_s;
    is_clr = rq && w && (a[3:2] == 2'd0) && wd[CTRL_CLR_BIT];
    ovf_s  = 1'b0;
    udf_s  = 1'b0;
    if (rq && !w && a[3]) begin
      if (mq.size() == 0) udf_s = 1'b1;
      else if (a[2]) void'(mq.pop_front());
    end
    if (cap && m_en && !is_clr) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else ovf_s = 1'b1;
    end
    if (is_clr) mq.delete();
    if (rq && w && (a[3:2] == 2'd1)) begin
      if (wd[STAT_OVF_BIT]) m_ovf = 1'b0;
      if (wd[STAT_UDF_BIT]) m_udf = 1'b0;
    end
    m_ovf = m_ovf | ovf_s;
    m_udf = m_udf | udf_s;
    if (rq && w && (a[3:2] == 2'd0)) begin
      m_en     = wd[CTRL_EN_BIT];
      m_irq_en = wd[CTRL_IRQ_EN_BIT];
    end
  endtask

  // One bus/capture cycle; called at posedge+1, returns at the next posedge+1.
  task automatic do_cycle(input logic cap, input logic [63:0] d, input logic rq,
                          input logic w, input logic [3:0] a, input logic [31:0] wd);
    logic [31:0] exp_rd;
    logic        exp_irq;
    capture   = cap;
    dout      = d;
    bus.req   = rq;
    bus.we    = w;
    bus.addr  = a;
    bus.wdata = wd;
    #1;
    chk("gnt", bus.gnt, rq);
    exp_rd  = (rq && !w) ? model_read(a) : 32'd0;
    exp_irq = m_irq_en && (mq.size() != 0);
    model_step(cap, d, rq, w, a, wd);
    @(posedge clk);
    #1;
    chk("rvalid", bus.rvalid, rq);
    if (rq) chk("rdata", bus.rdata, exp_rd);
    chk("irq", irq, exp_irq);
    last_rd = bus.rdata;
    capture = 1'b0;
    bus.req = 1'b0;
    bus.we  = 1'b0;
  endtask

  task automatic do_reset(input logic with_req);
    rst       = 1'b1;
    capture   = 1'b0;
    bus.req   = with_req;
    bus.we    = 1'b0;
    bus.addr  = 4'hC;
    bus.wdata = '0;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    bus.req = 1'b0;
    chk("rst_rvalid", bus.rvalid, 1'b0);
    chk("rst_rdata", bus.rdata, 32'd0);
    chk("rst_irq", irq, 1'b0);
    mq.delete();
    m_en = 1'b0; m_irq_en = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] wd);
    do_cycle(1'b0, 64'd0, 1'b1, 1'b1, a, wd);
  endtask

  task automatic rd(input logic [3:0] a);
    do_cycle(1'b0, 64'd0, 1'b1, 1'b0, a, 32'd0);
  endtask

  task automatic push_sample(input logic [63:0] d);
    do_cycle(1'b1, d, 1'b0, 1'b0, 4'h0, 32'd0);
  endtask

  task automatic idle();
    do_cycle(1'b0, 64'd0, 1'b0, 1'b0, 4'h0, 32'd0);
  endtask

  task automatic run_random(input int n);
    logic        c, rq, w;
    logic [3:0]  a;
    logic [31:0] wd;
    logic [63:0] d;
    int          sel;
    for (int i = 0; i < n; i++) begin
      c   = ($urandom_range(0, 99) < 55);
      d   = {$urandom, $urandom};
      rq  = ($urandom_range(0, 99) < 60);
      sel = $urandom_range(0, 15);
      w   = 1'b0;
      wd  = $urandom;
      a   = {2'b11, 2'($urandom_range(0, 3))};
      if (sel >= 8 && sel < 10) a[3:2] = 2'd2;
      else if (sel >= 10 && sel < 12) a[3:2] = 2'd1;
      else if (sel == 12) a[3:2] = 2'd0;
      else if (sel == 13) begin w = 1'b1; a[3:2] = 2'd1; end
      else if (sel == 14) begin
        w = 1'b1; a[3:2] = 2'd0;
        wd[CTRL_EN_BIT]  = ($urandom_range(0, 7) != 0);
        wd[CTRL_CLR_BIT] = ($urandom_range(0, 7) == 0);
      end else if (sel == 15) begin
        w = 1'b1; a[3] = 1'b1;
      end
      do_cycle(c, d, rq, w, a, wd);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] d0;
    d0 = 64'h1111_2222_3333_4444;
    bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;

    //          cap  d         req  we   addr   wdata          expected rdata
    tbl[0]  = '{1'b0, 64'd0,   1'b1, 1'b0, 4'h4, 32'h0,        32'h0000_0100};
    tbl[1]  = '{1'b0, 64'd0,   1'b1, 1'b0, 4'h0, 32'h0,        32'h0000_0000};
    tbl[2]  = '{1'b0, 64'd0,   1'b1, 1'b1, 4'h0, 32'h1,        32'h0000_0000};
    tbl[3]  = '{1'b1, d0,      1'b0, 1'b0, 4'h0, 32'h0,        32'h0};
    tbl[4]  = '{1'b1, d0 + 1,  1'b0, 1'b0, 4'h0, 32'h0,        32'h0};
    tbl[5]  = '{1'b1, d0 + 2,  1'b0, 1'b0, 4'h0, 32'h0,        32'h0};
    tbl[6]  = '{1'b0, 64'd0,   1'b1, 1'b0, 4'h4, 32'h0,        32'h0000_0003};
    tbl[7]  = '{1'b0, 64'd0,   1'b1, 1'b0, 4'h8, 32'h0,        32'h3333_4444};
    tbl[8]  = '{1'b0, 64'd0,   1'b1, 1'b0, 4'hC, 32'h0,        32'h1111_2222};
    tbl[9]  = '{1'b0, 64'd0,   1'b1, 1'b0, 4'h4, 32'h0,        32'h0000_0002};
    tbl[10] = '{1'b0, 64'd0,   1'b1, 1'b0, 4'h0, 32'h0,        32'h0000_0001};
    tbl[11] = '{1'b0, 64'd0,   1'b1, 1'b1, 4'h8, 32'hFFFF_FFFF, 32'h0000_0000};
    tbl[12] = '{1'b0, 64'd0,   1'b1, 1'b1, 4'h4, 32'h0000_0FFF, 32'h0000_0000};
    tbl[13] = '{1'b0, 64'd0,   1'b1, 1'b0, 4'h8, 32'h0,        32'h3333_4445};
    tbl[14] = '{1'b0, 64'd0,   1'b1, 1'b0, 4'hD, 32'h0,        32'h1111_2222};
    tbl[15] = '{1'b0, 64'd0,   1'b1, 1'b0, 4'h6, 32'h0,        32'h0000_0001};

    do_reset(1'b0);
    do_reset(1'b0);

    for (int i = 0; i < 16; i++) begin
      do_cycle(tbl[i].cap, tbl[i].d, tbl[i].req, tbl[i].we, tbl[i].addr, tbl[i].wdata);
      if (tbl[i].req) chk($sformatf("tbl[%0d]", i), last_rd, tbl[i].exp);
    end

    // Overflow on the 9th capture, W1C racing a new overflow, drain order.
    do_reset(1'b0);
    wr(4'h0, 32'h1);
    for (int k = 0; k < 9; k++) push_sample({32'h1000_0000 + 32'(k), 32'h2000_0000 + 32'(k)});
    rd(4'h4);
    chk("ovf_status", last_rd, 32'h0000_0608);
    do_cycle(1'b1, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, 1'b1, 4'h4, 32'h0000_0400);
    rd(4'h4);
    chk("w1c_vs_set", last_rd, 32'h0000_0608);
    for (int k = 0; k < 8; k++) begin
      rd(4'h8);
      chk("drain_lo", last_rd, 32'h2000_0000 + 32'(k));
      rd(4'hC);
      chk("drain_hi", last_rd, 32'h1000_0000 + 32'(k));
    end
    rd(4'h4);
    chk("drained_status", last_rd, 32'h0000_0500);
    rd(4'hC);
    chk("ninth_absent", last_rd, 32'h0);
    wr(4'h4, 32'h0000_0400);
    rd(4'h4);
    chk("ovf_cleared", last_rd, 32'h0000_0900);

    // Full FIFO: capture together with a pop is accepted.
    do_reset(1'b0);
    wr(4'h0, 32'h1);
    for (int k = 0; k < 8; k++) push_sample({32'h3000_0000 + 32'(k), 32'h4000_0000 + 32'(k)});
    do_cycle(1'b1, 64'h5555_6666_7777_8888, 1'b1, 1'b0, 4'hC, 32'h0);
    chk("full_pop_hi", last_rd, 32'h3000_0000);
    rd(4'h4);
    chk("full_push_pop_status", last_rd, 32'h0000_0208);
    for (int k = 0; k < 7; k++) rd(4'hC);
    rd(4'h8);
    chk("last_entry_lo", last_rd, 32'h7777_8888);
    rd(4'hC);
    chk("last_entry_hi", last_rd, 32'h5555_6666);

    // Empty FIFO pop is an underflow; irq stays low.
    do_reset(1'b0);
    wr(4'h0, 32'h5);
    rd(4'hC);
    chk("udf_rdata", last_rd, 32'h0);
    rd(4'h4);
    chk("udf_status", last_rd, 32'h0000_0900);
    chk("irq_empty", irq, 1'b0);

    // irq, clr and pointer wrap.
    do_reset(1'b0);
    wr(4'h0, 32'h5);
    rd(4'hC);
    for (int k = 0; k < 5; k++) push_sample(64'hABCD_0000_0000_0000 + 64'(k));
    idle();
    chk("irq_level", irq, 1'b1);
    wr(4'h0, 32'h7);
    rd(4'h4);
    chk("clr_status", last_rd, 32'h0000_0900);
    chk("irq_after_clr", irq, 1'b0);
    rd(4'h0);
    chk("clr_keeps_ctrl", last_rd, 32'h0000_0005);
    push_sample(64'h1);
    push_sample(64'h2);
    do_cycle(1'b1, 64'h3, 1'b1, 1'b1, 4'h0, 32'h7);
    rd(4'h4);
    chk("clr_beats_push", last_rd, 32'h0000_0900);
    for (int k = 0; k < 3; k++) push_sample({32'hC000_0000 + 32'(k), 32'hD000_0000 + 32'(k)});
    for (int k = 0; k < 12; k++) begin
      do_cycle(1'b1, {32'hC000_0000 + 32'(k + 3), 32'hD000_0000 + 32'(k + 3)},
               1'b1, 1'b0, 4'hC, 32'h0);
      chk("wrap_order", last_rd, 32'hC000_0000 + 32'(k));
    end
    for (int k = 12; k < 15; k++) begin
      rd(4'hC);
      chk("wrap_tail", last_rd, 32'hC000_0000 + 32'(k));
    end

    // Reset with a pending read aborts it.
    do_reset(1'b0);
    wr(4'h0, 32'h5);
    for (int k = 0; k < 4; k++) push_sample(64'h7777_0000_0000_0000 + 64'(k));
    idle();
    do_reset(1'b1);
    rd(4'h4);
    chk("rst_status", last_rd, 32'h0000_0100);
    rd(4'h0);
    chk("rst_ctrl", last_rd, 32'h0);
    chk("rst_irq_after", irq, 1'b0);

    // Randomized traffic against the model.
    do_reset(1'b0);
    wr(4'h0, 32'h5);
    run_random(1500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pmc_readout_fifo.md
PMC_READOUT_FIFO -- requirements
Module: pmc_readout_fifo

Interface
REQ-001 SHALL have one parameter: DEPTH, default 8, FIFO entries of 64 bits each, power of two, range 2..64.
REQ-002 SHALL use one clock and a synchronous, active-high reset; there are no other clocks or resets.
REQ-003 clk  in  1  sole clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous reset, active-high.
REQ-005 capture  in  1  single-cycle pulse from the PMC sequencer: sample dout now.
REQ-006 dout  in  64  pixel-matrix shift-register output word.
REQ-007 req  in  1  data-bus request, slave side.
REQ-008 we  in  1  write enable, qualified by req.
REQ-009 addr  in  4  byte offset within the block; bits [3:2] select the register, bits [1:0] are ignored.
REQ-010 wdata  in  32  write data.
REQ-011 gnt  out  1  bus grant.
REQ-012 rvalid  out  1  read/write completion.
REQ-013 rdata  out  32  read data, valid while rvalid=1.
REQ-014 irq  out  1  level interrupt: not empty and irq_en.

Function
REQ-015 Register map:
- 0x0 CTRL (RW): bit0 en, bit1 clr (self-clearing), bit2 irq_en.
- 0x4 STATUS: [6:0] count (RO), bit8 empty (RO), bit9 full (RO), bit10 ovf (W1C), bit11 udf (W1C).
- 0x8 DATA_LO (RO): head entry bits [31:0]; no pop.
- 0xC DATA_HI (RO): head entry bits [63:32]; pops the entry.
REQ-016 gnt SHALL equal req combinationally.
REQ-017 rvalid SHALL assert exactly one cycle after each granted request, for reads and writes alike.
REQ-018 rdata SHALL be registered, reflect FIFO/register state at the request cycle, and be 0 for writes.
REQ-019 Writes to read-only registers SHALL be ignored.
REQ-020 Push: capture=1, en=1 and not full SHALL write dout at the tail on that edge.
REQ-021 Capture is ignored when en=0.
REQ-022 Overflow: capture=1, en=1 and full SHALL drop the sample and set ovf; count and contents are unchanged.
REQ-023 Pop: a granted read of DATA_HI while not empty SHALL return the head high word and advance the head on the same edge.
REQ-024 A read of DATA_HI or DATA_LO while empty SHALL return 0, perform no pop, and set udf.
REQ-025 Simultaneous push and pop: when full, the push SHALL be accepted (not an overflow) and count is unchanged; when empty, the pop is an underflow and the push succeeds.
REQ-026 Pointers SHALL be log2(DEPTH) bits wide and wrap modulo DEPTH; count SHALL be log2(DEPTH)+1 bits, zero-extended into STATUS.
REQ-027 clr=1 written SHALL zero the pointers and count the next cycle.
REQ-028 clr SHALL take priority over a push or pop in the same cycle.
REQ-029 clr SHALL leave ovf/udf and the en/irq_en bits unchanged.
REQ-030 irq SHALL be registered and equal irq_en & ~empty, one cycle after the state changes.
REQ-031 A W1C write to ovf/udf in the same cycle as a new set event SHALL leave the bit set.

Reset
REQ-032 rst SHALL clear CTRL, ovf, udf, pointers and count.
REQ-033 rst SHALL drive gnt-independent outputs to: rvalid=0, rdata=0, irq=0.
REQ-034 FIFO storage SHALL NOT be reset; contents are don't-care after reset.
REQ-035 rst asserted mid-transaction SHALL abort the transaction; no rvalid is produced for it.

Structure
REQ-036 Register offsets, the STATUS/CTRL bit positions and a packed ctrl/status struct SHALL reside in shared package pmc_readout_pkg, alongside pmc_pkg.
REQ-037 FIFO storage and pointers SHALL be one sub-module, pmc_fifo64, with ports: push, pop, wdata, rdata, count, empty, full, clr.

Verification
REQ-038 en=1; 3 captures with dout=0x1111_2222_3333_4444, +1, +2 -> STATUS count=3; DATA_LO=0x3333_4444; DATA_HI=0x1111_2222 and count becomes 2.
REQ-039 DEPTH=8; 9 captures -> full=1, ovf=1, count=8; the 9th sample is absent on drain; W1C to ovf clears it.
REQ-040 Full FIFO; capture in the same cycle as a DATA_HI read -> count stays 8, ovf=0, new sample is the last entry.
REQ-041 Empty FIFO; DATA_HI read -> rdata=0, udf=1, count=0; irq stays 0.
REQ-042 Fill 5 entries with irq_en=1 (irq=1); write clr -> count=0 and irq=0 the next cycle; pop/push across wrap (12 push/pop pairs) preserves data order.
REQ-043 rst asserted with 4 entries and a read pending -> no rvalid, count=0, CTRL=0, irq=0.
